stopwatch_controller: RTL and testbench
=======================================

Name: stopwatch_controller

Overview:
Sequencing controller for the lab's 16-bit event counter, used as a stopwatch core. It converts single-cycle pulses from start_stop, lap and clear into run/pause/lap/clear control. A prescaler produces the count-enable tick, and the block owns the count register with modulo wrap. It drives a display bus that either follows the live count or holds a lap snapshot.

Parameters:
WIDTH, 16, width of count, display and lap snapshot
TICK_DIV, 50000, clock cycles per count increment (>=1)
MAX_COUNT, 9999, last count value before wrap to 0 (must fit in WIDTH)

Ports:
clock  input  1  single system clock, all logic on rising edge
reset  input  1  synchronous, active-low; 0 sampled at a rising edge resets the block
start_stop  input  1  one-cycle pulse, toggles run/pause
lap  input  1  one-cycle pulse, toggles lap hold
clear  input  1  one-cycle pulse, zeroes count (honoured only when paused)
count  output  WIDTH  live count register
display  output  WIDTH  lap_active ? lap snapshot : count
running  output  1  high in RUN and RUN_LAP
lap_active  output  1  high in RUN_LAP
overflow  output  1  one-cycle pulse on the wrap from MAX_COUNT to 0

Behaviour:
- Reset (reset==0 at a clock edge): state=IDLE; count, prescaler and lap snapshot =0; running, lap_active, overflow =0; display=0. Reset overrides every input, including mid-run and mid-lap.
- States: IDLE, RUN, RUN_LAP, PAUSED.
- Input priority when pulses coincide: clear > start_stop > lap. Only the highest-priority pulse that is legal in the current state takes effect; all others in that cycle are dropped.
- IDLE:
  - start_stop -> RUN, with prescaler =0.
  - lap and clear are ignored.
- RUN:
  - start_stop -> PAUSED.
  - lap -> RUN_LAP; lap snapshot <= count as it stands at that edge, pre-increment value if a tick coincides.
  - clear is ignored.
- RUN_LAP:
  - Counting continues; display holds the snapshot.
  - lap -> RUN; display returns to the live count.
  - start_stop -> PAUSED; lap hold is released.
  - clear is ignored.
- PAUSED:
  - start_stop -> RUN; prescaler resumes from its held value, so no phase loss.
  - clear -> IDLE; count=0, prescaler=0, snapshot=0.
  - lap is ignored.
- Prescaler:
  - Advances only in RUN and RUN_LAP, counting 0..TICK_DIV-1 and then returning to 0.
  - tick is asserted while prescaler==TICK_DIV-1, which enables count at that same edge.
  - TICK_DIV=1 gives a tick every running cycle.
- Count arithmetic:
  - On tick: if count==MAX_COUNT, count<=0 and overflow<=1 for exactly the next cycle; otherwise count<=count+1 (unsigned, WIDTH bits).
  - count holds in IDLE and PAUSED.
- Latency:
  - The first increment after leaving IDLE appears TICK_DIV cycles after the edge that entered RUN.
  - running and lap_active are registered state decodes, valid the cycle after the causing edge.
- A start_stop edge that pauses on the same cycle as a tick: the transition wins and the tick is not applied. The prescaler holds at TICK_DIV-1, so the tick fires on the first cycle after resume.

Test Plan:
- TICK_DIV=4, MAX_COUNT=9. Hold reset=0 for 2 cycles, then release -> count=0, display=0, running=0, state IDLE; clear and lap pulses in IDLE leave all outputs unchanged.
- start_stop pulse, then run 40 cycles -> running=1; count reaches 10 wraps = 0 at cycle 40 with count increments at cycles 4,8,...; overflow high for exactly 1 cycle after the 9->0 transition.
- In RUN at count=3: lap pulse -> lap_active=1, display stays 3 while count advances to 6; a second lap pulse -> display tracks count again.
- In RUN after 2 prescaler cycles: start_stop (pause) for 10 cycles -> count frozen; start_stop (resume) -> next increment 2 cycles later, confirming the prescaler held its phase.
- Coincident pulses: clear+start_stop in PAUSED -> IDLE with count=0; clear+lap in RUN -> RUN_LAP (clear illegal, lap taken); start_stop+lap in RUN -> PAUSED, lap_active=0.
- reset=0 asserted in RUN_LAP at count=5 -> next edge: count=0, display=0, lap_active=0, running=0, state IDLE; reset asserted between edges has no effect until sampled.

Source files
------------

// File: rtl/stopwatch_controller_if.sv
// Pulse inputs and display/status outputs of the stopwatch controller,
// bundled so the controller and its driver share one connection point.
interface stopwatch_controller_if #(
    parameter int WIDTH = 16
);
    logic             start_stop;
    logic             lap;
    logic             clear;
    logic [WIDTH-1:0] count;
    logic [WIDTH-1:0] display;
    logic             running;
    logic             lap_active;
    logic             overflow;

    // Side that issues the control pulses and watches the outputs
    modport master (
        output start_stop, lap, clear,
        input  count, display, running, lap_active, overflow
    );

    // Side implemented by the controller itself
    modport slave (
        input  start_stop, lap, clear,
        output count, display, running, lap_active, overflow
    );
endinterface

// File: rtl/stopwatch_controller.sv
// Stopwatch sequencing controller: run/pause/lap/clear FSM, count-enable
// prescaler, modulo count register and lap-snapshot display selection.
module stopwatch_controller #(
    parameter int WIDTH     = 16,
    parameter int TICK_DIV  = 50000,
    parameter int MAX_COUNT = 9999
) (
    input logic                   clock,
    input logic                   reset,
    stopwatch_controller_if.slave bus
);
    localparam int               PW         = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0]    PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [WIDTH-1:0] COUNT_LAST = WIDTH'(MAX_COUNT);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        RUN_LAP = 2'd2,
        PAUSED  = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] snap_q, snap_d;
    logic [PW-1:0]    presc_q, presc_d;
    logic             overflow_q, overflow_d;
    logic             advance;
    logic             tick;

    // Prescaler terminal value: enables a count step on this edge when advancing
    assign tick = (presc_q == PRESC_LAST);

    // Next-state: pulse priority clear > start_stop > lap, only legal pulses act
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        snap_d     = snap_q;
        presc_d    = presc_q;
        overflow_d = 1'b0;
        advance    = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.start_stop) begin
                    state_d = RUN;
                    presc_d = '0;
                end
            end
            RUN: begin
                // A pausing edge freezes prescaler and count, even on a tick
                if (bus.start_stop) begin
                    state_d = PAUSED;
                end else begin
                    advance = 1'b1;
                    if (bus.lap) begin
                        state_d = RUN_LAP;
                        snap_d  = count_q;
                    end
                end
            end
            RUN_LAP: begin
                if (bus.start_stop) begin
                    state_d = PAUSED;
                end else begin
                    advance = 1'b1;
                    if (bus.lap) begin
                        state_d = RUN;
                    end
                end
            end
            PAUSED: begin
                if (bus.clear) begin
                    state_d = IDLE;
                    count_d = '0;
                    presc_d = '0;
                    snap_d  = '0;
                end else if (bus.start_stop) begin
                    state_d = RUN;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (advance) begin
            if (tick) begin
                presc_d = '0;
                if (count_q == COUNT_LAST) begin
                    count_d    = '0;
                    overflow_d = 1'b1;
                end else begin
                    count_d = count_q + 1'b1;
                end
            end else begin
                presc_d = presc_q + 1'b1;
            end
        end
    end

    // State and datapath registers with synchronous active-low reset
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q    <= IDLE;
            count_q    <= '0;
            snap_q     <= '0;
            presc_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            snap_q     <= snap_d;
            presc_q    <= presc_d;
            overflow_q <= overflow_d;
        end
    end

    assign bus.count      = count_q;
    assign bus.display    = (state_q == RUN_LAP) ? snap_q : count_q;
    assign bus.running    = (state_q == RUN) || (state_q == RUN_LAP);
    assign bus.lap_active = (state_q == RUN_LAP);
    assign bus.overflow   = overflow_q;
endmodule

// File: tb/tb_stopwatch_controller.sv
// Self-checking bench for stopwatch_controller with TICK_DIV=4, MAX_COUNT=9.
module tb_stopwatch_controller;
    localparam int WIDTH = 16;
    localparam int TD    = 4;
    localparam int MAXC  = 9;

    logic clock = 1'b0;
    logic reset = 1'b1;

    stopwatch_controller_if #(.WIDTH(WIDTH)) sw_if ();

    stopwatch_controller #(
        .WIDTH(WIDTH),
        .TICK_DIV(TD),
        .MAX_COUNT(MAXC)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus(sw_if.slave)
    );

    always #5 clock = ~clock;

    int n_tests = 0;
    int n_fail  = 0;

    // Behavioural reference: mode flags, elapsed phase, count, snapshot
    bit               m_run, m_lap, m_paused, m_ovf;
    int               m_phase;
    logic [WIDTH-1:0] m_count, m_snap;

    task automatic model_step(input bit rn, input bit ss, input bit lp, input bit cl);
        if (!rn) begin
            m_run = 0; m_lap = 0; m_paused = 0; m_ovf = 0;
            m_phase = 0; m_count = '0; m_snap = '0;
            return;
        end
        m_ovf = 0;
        if (m_paused) begin
            if (cl) begin
                m_paused = 0; m_count = '0; m_phase = 0; m_snap = '0;
            end else if (ss) begin
                m_paused = 0; m_run = 1;
            end
        end else if (!m_run) begin
            if (ss) begin
                m_run = 1; m_phase = 0;
            end
        end else begin
            if (ss) begin
                m_run = 0; m_lap = 0; m_paused = 1;
            end else begin
                if (lp) begin
                    if (!m_lap) m_snap = m_count;
                    m_lap = !m_lap;
                end
                if (m_phase == TD - 1) begin
                    m_phase = 0;
                    if (int'(m_count) == MAXC) begin
                        m_count = '0;
                        m_ovf = 1;
                    end else begin
                        m_count = m_count + 1'b1;
                    end
                end else begin
                    m_phase = m_phase + 1;
                end
            end
        end
    endtask

    // One clock edge with the given reset level and pulses, model kept in step
    task automatic cyc(input bit rn, input bit ss, input bit lp, input bit cl);
        reset = rn;
        sw_if.start_stop = ss;
        sw_if.lap = lp;
        sw_if.clear = cl;
        @(posedge clock);
        model_step(rn, ss, lp, cl);
        #1;
        reset = 1'b1;
        sw_if.start_stop = 1'b0;
        sw_if.lap = 1'b0;
        sw_if.clear = 1'b0;
    endtask

    task automatic test_reset();
        cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 0);
        cyc(1, 0, 0, 0);
        n_tests++;
        if (sw_if.count !== 16'd0) begin n_fail++; $display("FAIL reset_count got %0d want 0", sw_if.count); end
        n_tests++;
        if (sw_if.display !== 16'd0) begin n_fail++; $display("FAIL reset_display got %0d want 0", sw_if.display); end
        n_tests++;
        if (sw_if.running !== 1'b0 || sw_if.lap_active !== 1'b0 || sw_if.overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_flags got run=%b lap=%b ovf=%b want 0 0 0", sw_if.running, sw_if.lap_active, sw_if.overflow);
        end
    endtask

    task automatic test_idle_ignore();
        cyc(1, 0, 0, 1);
        cyc(1, 0, 1, 0);
        cyc(1, 0, 1, 1);
        for (int k = 0; k < 6; k++) cyc(1, 0, 0, 0);
        n_tests++;
        if (sw_if.count !== 16'd0 || sw_if.display !== 16'd0 || sw_if.running !== 1'b0 || sw_if.lap_active !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_ignore got cnt=%0d disp=%0d run=%b lap=%b want 0 0 0 0",
                     sw_if.count, sw_if.display, sw_if.running, sw_if.lap_active);
        end
    endtask

    task automatic test_run_wrap();
        cyc(1, 1, 0, 0);
        n_tests++;
        if (sw_if.running !== 1'b1 || sw_if.count !== 16'd0) begin
            n_fail++; $display("FAIL run_start got run=%b cnt=%0d want 1 0", sw_if.running, sw_if.count);
        end
        for (int k = 1; k <= 40; k++) begin
            cyc(1, 0, 0, 0);
            n_tests++;
            if (sw_if.count !== 16'((k / TD) % (MAXC + 1))) begin
                n_fail++; $display("FAIL run_count k=%0d got %0d want %0d", k, sw_if.count, (k / TD) % (MAXC + 1));
            end
            n_tests++;
            if (sw_if.overflow !== (k == 40)) begin
                n_fail++; $display("FAIL run_overflow k=%0d got %b want %b", k, sw_if.overflow, (k == 40));
            end
        end
    endtask

    task automatic test_lap();
        for (int k = 0; k < 12; k++) cyc(1, 0, 0, 0);
        n_tests++;
        if (sw_if.count !== 16'd3) begin n_fail++; $display("FAIL lap_pre_count got %0d want 3", sw_if.count); end
        cyc(1, 0, 1, 0);
        n_tests++;
        if (sw_if.lap_active !== 1'b1 || sw_if.display !== 16'd3 || sw_if.overflow !== 1'b0) begin
            n_fail++; $display("FAIL lap_enter got lap=%b disp=%0d ovf=%b want 1 3 0", sw_if.lap_active, sw_if.display, sw_if.overflow);
        end
        for (int k = 0; k < 11; k++) begin
            cyc(1, 0, 0, 0);
            n_tests++;
            if (sw_if.display !== 16'd3 || sw_if.running !== 1'b1) begin
                n_fail++; $display("FAIL lap_hold got disp=%0d run=%b want 3 1", sw_if.display, sw_if.running);
            end
        end
        n_tests++;
        if (sw_if.count !== 16'd6) begin n_fail++; $display("FAIL lap_live_count got %0d want 6", sw_if.count); end
        cyc(1, 0, 1, 0);
        n_tests++;
        if (sw_if.lap_active !== 1'b0 || sw_if.display !== 16'd6) begin
            n_fail++; $display("FAIL lap_exit got lap=%b disp=%0d want 0 6", sw_if.lap_active, sw_if.display);
        end
    endtask

    task automatic test_pause_phase();
        cyc(0, 0, 0, 0);
        cyc(1, 1, 0, 0);
        cyc(1, 0, 0, 0);
        cyc(1, 0, 0, 0);
        cyc(1, 1, 0, 0);
        n_tests++;
        if (sw_if.running !== 1'b0 || sw_if.count !== 16'd0) begin
            n_fail++; $display("FAIL pause_enter got run=%b cnt=%0d want 0 0", sw_if.running, sw_if.count);
        end
        for (int k = 0; k < 10; k++) cyc(1, 0, 0, 0);
        n_tests++;
        if (sw_if.count !== 16'd0) begin n_fail++; $display("FAIL pause_frozen got %0d want 0", sw_if.count); end
        cyc(1, 1, 0, 0);
        cyc(1, 0, 0, 0);
        n_tests++;
        if (sw_if.count !== 16'd0 || sw_if.running !== 1'b1) begin
            n_fail++; $display("FAIL resume_one got cnt=%0d run=%b want 0 1", sw_if.count, sw_if.running);
        end
        cyc(1, 0, 0, 0);
        n_tests++;
        if (sw_if.count !== 16'd1) begin n_fail++; $display("FAIL resume_phase got %0d want 1", sw_if.count); end
    endtask

    task automatic test_coincident();
        cyc(1, 1, 0, 0);
        cyc(1, 1, 0, 1);
        cyc(1, 0, 0, 0);
        n_tests++;
        if (sw_if.count !== 16'd0 || sw_if.running !== 1'b0) begin
            n_fail++; $display("FAIL clear_ss got cnt=%0d run=%b want 0 0", sw_if.count, sw_if.running);
        end
        cyc(1, 0, 1, 0);
        n_tests++;
        if (sw_if.lap_active !== 1'b0 || sw_if.running !== 1'b0) begin
            n_fail++; $display("FAIL idle_after_clear got lap=%b run=%b want 0 0", sw_if.lap_active, sw_if.running);
        end
        cyc(1, 1, 0, 0);
        cyc(1, 0, 1, 1);
        n_tests++;
        if (sw_if.lap_active !== 1'b1 || sw_if.running !== 1'b1) begin
            n_fail++; $display("FAIL clear_lap got lap=%b run=%b want 1 1", sw_if.lap_active, sw_if.running);
        end
        cyc(1, 0, 1, 0);
        cyc(1, 1, 1, 0);
        n_tests++;
        if (sw_if.running !== 1'b0 || sw_if.lap_active !== 1'b0) begin
            n_fail++; $display("FAIL ss_lap got run=%b lap=%b want 0 0", sw_if.running, sw_if.lap_active);
        end
        cyc(1, 1, 0, 0);
        n_tests++;
        if (sw_if.running !== 1'b1) begin n_fail++; $display("FAIL paused_resume got run=%b want 1", sw_if.running); end
    endtask

    task automatic test_reset_midrun();
        cyc(0, 0, 0, 0);
        cyc(1, 1, 0, 0);
        for (int k = 0; k < 20; k++) cyc(1, 0, 0, 0);
        cyc(1, 0, 1, 0);
        n_tests++;
        if (sw_if.lap_active !== 1'b1 || sw_if.display !== 16'd5) begin
            n_fail++; $display("FAIL midrun_lap got lap=%b disp=%0d want 1 5", sw_if.lap_active, sw_if.display);
        end
        reset = 1'b0;
        #1;
        n_tests++;
        if (sw_if.count !== 16'd5 || sw_if.lap_active !== 1'b1) begin
            n_fail++; $display("FAIL reset_unsampled got cnt=%0d lap=%b want 5 1", sw_if.count, sw_if.lap_active);
        end
        cyc(0, 0, 0, 0);
        n_tests++;
        if (sw_if.count !== 16'd0 || sw_if.display !== 16'd0 || sw_if.lap_active !== 1'b0 || sw_if.running !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_midrun got cnt=%0d disp=%0d lap=%b run=%b want 0 0 0 0",
                     sw_if.count, sw_if.display, sw_if.lap_active, sw_if.running);
        end
    endtask

    task automatic test_random();
        bit rn, ss, lp, cl;
        cyc(0, 0, 0, 0);
        for (int k = 0; k < 2000; k++) begin
            rn = ($urandom_range(0, 299) != 0);
            ss = ($urandom_range(0, 9) == 0);
            lp = ($urandom_range(0, 6) == 0);
            cl = ($urandom_range(0, 6) == 0);
            cyc(rn, ss, lp, cl);
            n_tests++;
            if (sw_if.count !== m_count || sw_if.display !== (m_lap ? m_snap : m_count) ||
                sw_if.running !== m_run || sw_if.lap_active !== m_lap || sw_if.overflow !== m_ovf) begin
                n_fail++;
                $display("FAIL random k=%0d got cnt=%0d disp=%0d run=%b lap=%b ovf=%b want %0d %0d %b %b %b",
                         k, sw_if.count, sw_if.display, sw_if.running, sw_if.lap_active, sw_if.overflow,
                         m_count, (m_lap ? m_snap : m_count), m_run, m_lap, m_ovf);
            end
        end
    endtask

    initial begin
        sw_if.start_stop = 1'b0;
        sw_if.lap = 1'b0;
        sw_if.clear = 1'b0;
        @(negedge clock);
        test_reset();
        test_idle_ignore();
        test_run_wrap();
        test_lap();
        test_pause_phase();
        test_coincident();
        test_reset_midrun();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "timeout");
    end
endmodule
